// File: rtl/dvi_pkg.sv
// Shared constants and helpers for the DVI/TMDS encoder.
package dvi_pkg;
  localparam int CNT_W = 5;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b0, d[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    logic [9:0] t;
    case ({c1, c0})
      2'b00:   t = CTRL_00;
      2'b01:   t = CTRL_01;
      2'b10:   t = CTRL_10;
      default: t = CTRL_11;
    endcase
    return t;
  endfunction
endpackage

// File: rtl/dvi_encoder_tmds_channel.sv
// One TMDS lane: transition minimisation (stage 1) then DC balancing (stage 2).
module tmds_channel
  import dvi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_de,
  input  logic       i_c1,
  input  logic       i_c0,
  output logic [9:0] o_sym
);
  logic [3:0]       w_n1d;
  logic             w_xnor;
  logic [8:0]       w_qm;
  logic [8:0]       r_qm;
  logic             r_de;
  logic [1:0]       r_ctrl;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_n1q;
  logic [CNT_W-1:0] w_diff;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [9:0]       w_sym;

  assign w_n1d  = popcount8(i_data);
  assign w_xnor = (w_n1d > 4'd4) || (w_n1d == 4'd4 && !i_data[0]);

  always_comb begin
    w_qm    = '0;
    w_qm[0] = i_data[0];
    for (int i = 1; i < 8; i++)
      w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
    w_qm[8] = ~w_xnor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_qm   <= '0;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      r_qm   <= w_qm;
      r_de   <= i_de;
      r_ctrl <= {i_c1, i_c0};
    end
  end

  // N1 - N0 = 2*N1 - 8, kept in modular CNT_W-bit two's complement
  assign w_n1q  = popcount8(r_qm[7:0]);
  assign w_diff = {w_n1q, 1'b0} - 5'd8;

  always_comb begin
    w_sym    = ctrl_token(r_ctrl[1], r_ctrl[0]);
    w_cnt_nx = '0;
    if (r_de) begin
      if (r_cnt == '0 || w_diff == '0) begin
        w_sym    = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
        w_cnt_nx = r_qm[8] ? r_cnt + w_diff : r_cnt - w_diff;
      end else if (r_cnt[CNT_W-1] == w_diff[CNT_W-1]) begin
        // both nonzero here, so equal sign bits mean the word would grow the imbalance
        w_sym    = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt_nx = r_cnt + {3'b0, r_qm[8], 1'b0} - w_diff;
      end else begin
        w_sym    = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt_nx = r_cnt - {3'b0, ~r_qm[8], 1'b0} + w_diff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_sym <= CTRL_00;
      r_cnt <= '0;
    end else begin
      o_sym <= w_sym;
      r_cnt <= w_cnt_nx;
    end
  end
endmodule

// File: rtl/dvi_encoder.sv
// 4-bit RGB + sync to three TMDS symbol streams, 2-cycle latency.
module dvi_encoder
  import dvi_pkg::*;
#(
  parameter bit INVERT_SYNC = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] video_r,
  input  logic [3:0] video_g,
  input  logic [3:0] video_b,
  input  logic       video_de,
  input  logic       video_hsync,
  input  logic       video_vsync,
  output logic [9:0] tmds_d0,
  output logic [9:0] tmds_d1,
  output logic [9:0] tmds_d2
);
  logic w_hs, w_vs;

  assign w_hs = video_hsync ^ INVERT_SYNC;
  assign w_vs = video_vsync ^ INVERT_SYNC;

  tmds_channel u_ch0 (
    .clk(clk), .reset(reset), .i_data({video_b, video_b}), .i_de(video_de),
    .i_c1(w_vs), .i_c0(w_hs), .o_sym(tmds_d0)
  );

  tmds_channel u_ch1 (
    .clk(clk), .reset(reset), .i_data({video_g, video_g}), .i_de(video_de),
    .i_c1(1'b0), .i_c0(1'b0), .o_sym(tmds_d1)
  );

  tmds_channel u_ch2 (
    .clk(clk), .reset(reset), .i_data({video_r, video_r}), .i_de(video_de),
    .i_c1(1'b0), .i_c0(1'b0), .o_sym(tmds_d2)
  );
endmodule

// File: tb/tb_dvi_encoder.sv
// Directed and stream checks for dvi_encoder; inputs change on negedge, outputs read on negedge.
module tb_dvi_encoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] vr = '0, vg = '0, vb = '0;
  logic       de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [9:0] d0, d1, d2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  dvi_encoder dut (
    .clk(clk), .reset(reset), .video_r(vr), .video_g(vg), .video_b(vb),
    .video_de(de), .video_hsync(hs), .video_vsync(vs),
    .tmds_d0(d0), .tmds_d1(d1), .tmds_d2(d2)
  );

  // Apply a vector and advance one clock; afterwards the outputs show the previous vector.
  task automatic drive(input logic [3:0] r, g, b, input logic e, h, v);
    vr = r; vg = g; vb = b; de = e; hs = h; vs = v;
    @(negedge clk);
  endtask

  function automatic logic [9:0] tok(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Receiver-side TMDS data decode, independent of the encoder's decision logic.
  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] d, q;
    d = s[9] ? ~s[7:0] : s[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return q;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'($urandom), 1'($urandom));
      n_cmp++;
      if ({d2, d1, d0} !== {3{10'h354}}) begin
        n_bad++;
        $display("FAIL reset_hold[%0d] got %h %h %h want 354 x3", k, d2, d1, d0);
      end
    end
    reset = 1'b0;
    drive(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({d2, d1, d0} !== {3{10'h354}}) begin
      n_bad++;
      $display("FAIL reset_after got %h %h %h want 354 x3", d2, d1, d0);
    end
  endtask

  task automatic test_ctrl();
    logic [9:0] exp0 [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1'b0, 1'(k + 1), 1'((k + 1) >> 1));
      if (k == 0) drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ctrl_sweep();
    logic [9:0] exp0 [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1'b0, (k < 4) ? 1'(k) : 1'b0, (k < 4) ? 1'(k >> 1) : 1'b0);
      drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    // Streamed sweep: vector k is visible after the drive of vector k+1
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1'b0, (k < 3) ? 1'(k + 1) : 1'b0, (k < 3) ? 1'((k + 1) >> 1) : 1'b0);
      n_cmp++;
      if ({d2, d1, d0} !== {10'h354, 10'h354, exp0[k]}) begin
        n_bad++;
        $display("FAIL ctrl_%0d got %h %h %h want 354 354 %h", k, d2, d1, d0, exp0[k]);
      end
    end
  endtask

  task automatic test_zeros();
    logic [9:0] exp [3] = '{10'h100, 10'h3FF, 10'h100};
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, (k < 2), 1'b0, 1'b0);
      n_cmp++;
      if ({d2, d1, d0} !== {3{exp[k]}}) begin
        n_bad++;
        $display("FAIL zeros_%0d got %h %h %h want %h x3", k, d2, d1, d0, exp[k]);
      end
    end
    // de fell: the third pixel was in flight; now the token must follow
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({d2, d1, d0} !== {3{10'h354}}) begin
      n_bad++;
      $display("FAIL de_fall got %h %h %h want 354 x3", d2, d1, d0);
    end
  endtask

  // r=0 walks cases A/B/C; g=F takes the XNOR path; b=5 stays balanced (0x133).
  task automatic test_mixed();
    logic [9:0] er [4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    logic [9:0] eg [4] = '{10'h200, 10'h0FF, 10'h0FF, 10'h200};
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 1'b0);
      else       drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({d2, d1, d0} !== {er[k], eg[k], 10'h133}) begin
        n_bad++;
        $display("FAIL mixed_%0d got %h %h %h want %h %h 133", k, d2, d1, d0, er[k], eg[k]);
      end
    end
    drive(4'hF, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({d2, d1, d0} !== {10'h354, 10'h354, 10'h0AB}) begin
      n_bad++;
      $display("FAIL mixed_hsync got %h %h %h want 354 354 0ab", d2, d1, d0);
    end
  endtask

  // First pixel after a control period must see cnt = 0 again.
  task automatic test_back_to_back();
    drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({d2, d1, d0} !== {10'h200, 10'h100, 10'h200}) begin
      n_bad++;
      $display("FAIL b2b_first got %h %h %h want 200 100 200", d2, d1, d0);
    end
    drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({d2, d1, d0} !== {10'h354, 10'h354, 10'h154}) begin
      n_bad++;
      $display("FAIL b2b_vsync got %h %h %h want 354 354 154", d2, d1, d0);
    end
  endtask

  task automatic test_reset_midline();
    drive(4'h3, 4'h9, 4'hC, 1'b1, 1'b0, 1'b0);
    drive(4'h3, 4'h9, 4'hC, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    drive(4'h3, 4'h9, 4'hC, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({d2, d1, d0} !== {3{10'h354}}) begin
      n_bad++;
      $display("FAIL midreset got %h %h %h want 354 x3", d2, d1, d0);
    end
    reset = 1'b0;
    drive(4'h3, 4'h9, 4'hC, 1'b0, 1'b1, 1'b0);
    drive(4'h3, 4'h9, 4'hC, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({d2, d1, d0} !== {10'h354, 10'h354, 10'h0AB}) begin
      n_bad++;
      $display("FAIL midreset_tok got %h %h %h want 354 354 0ab", d2, d1, d0);
    end
  endtask

  // Random bursts: decode must return {x,x}, control must be the right token,
  // and the line's running symbol disparity must stay within +/-10.
  task automatic test_stream();
    logic [3:0] pr = '0, pg = '0, pb = '0;
    logic       pde = 1'b0, ph = 1'b0, pv = 1'b0;
    logic [3:0] nr, ng, nb;
    logic       nde = 1'b0, nh, nv;
    logic [9:0] sy [3];
    logic [3:0] px [3];
    int         disp [3] = '{0, 0, 0};
    int         run = 0;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        nde = ~nde;
        run = nde ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      end
      run--;
      nr = 4'($urandom); ng = 4'($urandom); nb = 4'($urandom);
      nh = 1'($urandom); nv = 1'($urandom);
      drive(nr, ng, nb, nde, nh, nv);
      sy = '{d0, d1, d2};
      px = '{pb, pg, pr};
      if (pde) begin
        for (int ch = 0; ch < 3; ch++) begin
          disp[ch] += 2 * $countones(sy[ch]) - 10;
          n_cmp++;
          if (dec(sy[ch]) !== {px[ch], px[ch]}) begin
            n_bad++;
            $display("FAIL stream_dec ch%0d cyc%0d got %h want %h", ch, c, dec(sy[ch]), {px[ch], px[ch]});
          end
          n_cmp++;
          if (disp[ch] > 10 || disp[ch] < -10) begin
            n_bad++;
            $display("FAIL stream_disp ch%0d cyc%0d got %0d want within +/-10", ch, c, disp[ch]);
          end
        end
      end else begin
        disp = '{0, 0, 0};
        n_cmp++;
        if ({d2, d1, d0} !== {10'h354, 10'h354, tok(pv, ph)}) begin
          n_bad++;
          $display("FAIL stream_tok cyc%0d got %h %h %h want 354 354 %h", c, d2, d1, d0, tok(pv, ph));
        end
      end
      pr = nr; pg = ng; pb = nb; pde = nde; ph = nh; pv = nv;
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_sweep();
    test_zeros();
    test_mixed();
    test_back_to_back();
    test_reset_midline();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
